// File: rtl/regfile_cmd_master_if.sv
// Command, response and register-file port bundle for regfile_cmd_master.
// master = the command engine's view; slave = host plus register-file side.
interface regfile_cmd_master_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_op;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] rf_read_addr1;
    logic [ADDR_W-1:0] rf_read_addr2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;

    modport master (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_op, rsp_data1, rsp_data2,
        input  rsp_ready,
        output rf_we, rf_write_addr, rf_write_data, rf_read_addr1, rf_read_addr2,
        input  rf_read_data1, rf_read_data2
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_op, rsp_data1, rsp_data2,
        output rsp_ready,
        input  rf_we, rf_write_addr, rf_write_data, rf_read_addr1, rf_read_addr2,
        output rf_read_data1, rf_read_data2
    );
endinterface

// File: rtl/regfile_cmd_master.sv
// WRITE/READ/COPY/SWAP sequencer for a 1W/2R register file; response one edge after EXEC (two for SWAP).
// One command in flight: cmd_ready only in IDLE, response held until rsp_ready handshake.
module regfile_cmd_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_cmd_master_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SWAP2 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] rsp1_q, rsp1_d;
    logic [DATA_W-1:0] rsp2_q, rsp2_d;
    logic [DATA_W-1:0] tmp_q, tmp_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            rsp1_q  <= '0;
            rsp2_q  <= '0;
            tmp_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rsp1_q  <= rsp1_d;
            rsp2_q  <= rsp2_d;
            tmp_q   <= tmp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rsp1_d  = rsp1_q;
        rsp2_d  = rsp2_q;
        tmp_d   = tmp_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.op   = bus.cmd_op;
                    cmd_d.ra   = bus.cmd_ra;
                    cmd_d.rb   = bus.cmd_rb;
                    cmd_d.data = bus.cmd_data;
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Read ports are combinational, so this cycle still sees pre-op contents.
                rsp1_d  = bus.rf_read_data1;
                rsp2_d  = bus.rf_read_data2;
                state_d = ST_RESP;
                case (cmd_q.op)
                    OP_WRITE: begin
                        wr_en   = 1'b1;
                        wr_addr = cmd_q.ra;
                        wr_data = cmd_q.data;
                    end
                    OP_READ: begin
                        wr_en = 1'b0;
                    end
                    OP_COPY: begin
                        wr_en   = 1'b1;
                        wr_addr = cmd_q.rb;
                        wr_data = bus.rf_read_data1;
                    end
                    OP_SWAP: begin
                        wr_en   = 1'b1;
                        wr_addr = cmd_q.rb;
                        wr_data = bus.rf_read_data1;
                        tmp_d   = bus.rf_read_data2;
                        state_d = ST_SWAP2;
                    end
                    default: wr_en = 1'b0;
                endcase
            end

            ST_SWAP2: begin
                // Second half of the swap uses the rb value captured before it was overwritten.
                wr_en   = 1'b1;
                wr_addr = cmd_q.ra;
                wr_data = tmp_q;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = (state_q == ST_RESP);
    assign bus.rsp_op        = cmd_q.op;
    assign bus.rsp_data1     = rsp1_q;
    assign bus.rsp_data2     = rsp2_q;
    assign bus.rf_we         = wr_en;
    assign bus.rf_write_addr = wr_addr;
    assign bus.rf_write_data = wr_data;
    assign bus.rf_read_addr1 = cmd_q.ra;
    assign bus.rf_read_addr2 = cmd_q.rb;

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed and model-checked bench for regfile_cmd_master with a behavioural 4x8 register file.
module tb_regfile_cmd_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [1:0] wlog_a [$];
    logic [7:0] wlog_d [$];

    regfile_cmd_master_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    regfile_cmd_master #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rf_read_data1 = rf[bus.rf_read_addr1];
    assign bus.rf_read_data2 = rf[bus.rf_read_addr2];

    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) begin
            rf[bus.rf_write_addr] <= bus.rf_write_data;
            wlog_a.push_back(bus.rf_write_addr);
            wlog_d.push_back(bus.rf_write_data);
        end
    end

    // Issues one command, waits for its response, then completes the handshake
    // after holding rsp_ready low for 'hold' cycles. Returns #1 after the handshake edge.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [7:0] dat, input int hold,
                          output logic [1:0] rop, output logic [7:0] d1, output logic [7:0] d2,
                          output int lat, output int acc_cyc);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        bus.cmd_data  = dat;
        bus.rsp_ready = (hold == 0);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL accept_timeout cmd_ready=%b required=1", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL rsp_timeout rsp_valid=%b required=1", bus.rsp_valid);
        end
        rop = bus.rsp_op;
        d1  = bus.rsp_data1;
        d2  = bus.rsp_data2;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_ra    = 2'd0;
        bus.cmd_rb    = 2'd0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rsp_valid=%b rf_we=%b required=0,0", bus.rsp_valid, bus.rf_we);
        end
        checks++;
        if (bus.rsp_op !== 2'b00 || bus.rsp_data1 !== 8'h00 || bus.rsp_data2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp op=%h d1=%h d2=%h required=0,00,00",
                     bus.rsp_op, bus.rsp_data1, bus.rsp_data2);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b required=1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_read();
        logic [1:0] rop;
        logic [7:0] d1, d2;
        int lat, ac;
        wlog_a.delete(); wlog_d.delete();
        do_cmd(2'b00, 2'd2, 2'd1, 8'hA5, 0, rop, d1, d2, lat, ac);
        checks++;
        if (wlog_a.size() != 1 || wlog_a[0] !== 2'd2 || wlog_d[0] !== 8'hA5) begin
            failures++;
            $display("FAIL write_pulse writes=%0d required=1 at addr 2 data a5", wlog_a.size());
        end
        checks++;
        if (lat != 1 || rop !== 2'b00) begin
            failures++;
            $display("FAIL write_rsp lat=%0d op=%h required=1,0", lat, rop);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_idle cmd_ready=%b rsp_valid=%b required=1,0", bus.cmd_ready, bus.rsp_valid);
        end
        do_cmd(2'b01, 2'd2, 2'd2, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (d1 !== 8'hA5 || d2 !== 8'hA5 || rop !== 2'b01 || lat != 1) begin
            failures++;
            $display("FAIL read_same d1=%h d2=%h op=%h lat=%0d required=a5,a5,1,1", d1, d2, rop, lat);
        end
    endtask

    task automatic test_swap();
        logic [1:0] rop;
        logic [7:0] d1, d2;
        int lat, ac;
        do_cmd(2'b00, 2'd0, 2'd0, 8'h11, 0, rop, d1, d2, lat, ac);
        do_cmd(2'b00, 2'd3, 2'd3, 8'h33, 0, rop, d1, d2, lat, ac);
        wlog_a.delete(); wlog_d.delete();
        do_cmd(2'b11, 2'd0, 2'd3, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (wlog_a.size() != 2) begin
            failures++;
            $display("FAIL swap_we_count got=%0d required=2", wlog_a.size());
        end else if (wlog_a[0] !== 2'd3 || wlog_d[0] !== 8'h11 || wlog_a[1] !== 2'd0 || wlog_d[1] !== 8'h33) begin
            failures++;
            $display("FAIL swap_we_seq got=%h:%h,%h:%h required=3:11,0:33",
                     wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]);
        end
        checks++;
        if (d1 !== 8'h11 || d2 !== 8'h33 || lat != 2 || rop !== 2'b11) begin
            failures++;
            $display("FAIL swap_rsp d1=%h d2=%h lat=%0d op=%h required=11,33,2,3", d1, d2, lat, rop);
        end
        do_cmd(2'b01, 2'd0, 2'd3, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (d1 !== 8'h33 || d2 !== 8'h11) begin
            failures++;
            $display("FAIL swap_readback d1=%h d2=%h required=33,11", d1, d2);
        end
    endtask

    task automatic test_copy();
        logic [1:0] rop;
        logic [7:0] d1, d2;
        int lat, ac;
        do_cmd(2'b00, 2'd1, 2'd1, 8'h7E, 0, rop, d1, d2, lat, ac);
        do_cmd(2'b10, 2'd1, 2'd0, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (d1 !== 8'h7E || d2 !== 8'h33 || rf[0] !== 8'h7E || lat != 1) begin
            failures++;
            $display("FAIL copy_rsp d1=%h d2=%h r0=%h lat=%0d required=7e,33,7e,1", d1, d2, rf[0], lat);
        end
        wlog_a.delete(); wlog_d.delete();
        do_cmd(2'b10, 2'd1, 2'd1, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (wlog_a.size() != 1 || rf[1] !== 8'h7E || d1 !== 8'h7E || d2 !== 8'h7E || lat != 1) begin
            failures++;
            $display("FAIL copy_self writes=%0d r1=%h d1=%h d2=%h lat=%0d required=1,7e,7e,7e,1",
                     wlog_a.size(), rf[1], d1, d2, lat);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_ra    = 2'd2;
        bus.cmd_rb    = 2'd3;
        @(posedge clk);
        #1;
        bus.cmd_op   = 2'b00;
        bus.cmd_data = 8'hFF;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== 8'hA5 || bus.rsp_data2 !== 8'h11 ||
                bus.rsp_op !== 2'b01 || bus.cmd_ready !== 1'b0 || bus.rf_we !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d required=0 (last d1=%h d2=%h)", bad, bus.rsp_data1, bus.rsp_data2);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || rf[2] !== 8'hA5) begin
            failures++;
            $display("FAIL bp_release rsp_valid=%b cmd_ready=%b r2=%h required=0,1,a5",
                     bus.rsp_valid, bus.cmd_ready, rf[2]);
        end
    endtask

    task automatic test_reset_swap2();
        logic [1:0] rop;
        logic [7:0] d1, d2;
        int lat, ac;
        wlog_a.delete(); wlog_d.delete();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_ra    = 2'd1;
        bus.cmd_rb    = 2'd2;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_write_addr !== 2'd1) begin
            failures++;
            $display("FAIL swap2_entry rf_we=%b addr=%h required=1,1", bus.rf_we, bus.rf_write_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL swap2_reset rf_we=%b rsp_valid=%b required=0,0", bus.rf_we, bus.rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wlog_a.size() != 1 || rf[2] !== 8'h7E || rf[1] !== 8'h7E) begin
            failures++;
            $display("FAIL swap2_file writes=%0d r1=%h r2=%h required=1,7e,7e", wlog_a.size(), rf[1], rf[2]);
        end
        do_cmd(2'b00, 2'd1, 2'd2, 8'h5C, 0, rop, d1, d2, lat, ac);
        do_cmd(2'b01, 2'd1, 2'd2, 8'h00, 0, rop, d1, d2, lat, ac);
        checks++;
        if (d1 !== 8'h5C || d2 !== 8'h7E || lat != 1) begin
            failures++;
            $display("FAIL post_reset_cmd d1=%h d2=%h lat=%0d required=5c,7e,1", d1, d2, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rop;
        logic [7:0] d1, d2;
        int lat, a1, a2;
        do_cmd(2'b00, 2'd3, 2'd0, 8'hC3, 0, rop, d1, d2, lat, a1);
        checks++;
        if (d1 !== 8'h11 || d2 !== 8'h7E) begin
            failures++;
            $display("FAIL b2b_write_rsp d1=%h d2=%h required=11,7e", d1, d2);
        end
        do_cmd(2'b01, 2'd3, 2'd0, 8'h00, 0, rop, d1, d2, lat, a2);
        checks++;
        if (a2 - a1 != 3 || d1 !== 8'hC3 || d2 !== 8'h7E) begin
            failures++;
            $display("FAIL b2b_spacing edges=%0d d1=%h d2=%h required=3,c3,7e", a2 - a1, d1, d2);
        end
    endtask

    task automatic test_random();
        logic [7:0] m [4];
        logic [1:0] op, ra, rb, rop;
        logic [7:0] dat, d1, d2, e1, e2;
        int lat, ac, bad;
        logic [7:0] t1;
        for (int i = 0; i < 4; i++) begin
            t1 = 8'h21 + 8'(i * 8'h13);
            do_cmd(2'b00, 2'(i), 2'(i), t1, 0, rop, d1, d2, lat, ac);
            m[i] = t1;
        end
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            op  = 2'($urandom_range(0, 3));
            ra  = 2'($urandom_range(0, 3));
            rb  = 2'($urandom_range(0, 3));
            dat = 8'($urandom_range(0, 255));
            e1 = m[ra];
            e2 = m[rb];
            do_cmd(op, ra, rb, dat, $urandom_range(0, 2), rop, d1, d2, lat, ac);
            case (op)
                2'b00: m[ra] = dat;
                2'b10: m[rb] = e1;
                2'b11: begin m[rb] = e1; m[ra] = e2; end
                default: ;
            endcase
            checks++;
            if (d1 !== e1 || d2 !== e2 || rop !== op || lat != (op == 2'b11 ? 2 : 1)) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand_rsp k=%0d op=%h d1=%h d2=%h lat=%0d required=%h,%h", k, op, d1, d2, lat, e1, e2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf[i] !== m[i]) begin
                failures++;
                $display("FAIL rand_final r%0d got=%h required=%h", i, rf[i], m[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_swap();
        test_copy();
        test_backpressure();
        test_reset_swap2();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
